// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle RICPU control FSM (IF/ID/EX/MEM/WB)
// Optional single-step gating of IF when MCC_STEP_EN is defined.
module multi_cycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
`ifdef MCC_STEP_EN
    input  logic       step,
`endif
    input  logic [5:0] op_code,
    input  logic [5:0] func,
    input  logic       ZF,
    output logic       PC_Write,
    output logic [1:0] PC_s,
    output logic       IR_Write,
    output logic       Write_Reg,
    output logic       Mem_Write,
    output logic [2:0] ALU_OP,
    output logic       rd_rt_s,
    output logic       imm_s,
    output logic       rt_imm_s,
    output logic       alu_mem_s,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       step_ok;
    logic       dec_ok, is_j, is_beq, is_lw, is_sw;
    logic [2:0] dec_alu;
    logic       dec_rdrt, dec_imm, dec_rtimm;

`ifdef MCC_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    // Instruction decode from the IR fields; valid from ID onward.
    always_comb begin
        dec_ok    = 1'b1;
        is_j      = 1'b0;
        is_beq    = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        dec_alu   = 3'b000;
        dec_rdrt  = 1'b0;
        dec_imm   = 1'b0;
        dec_rtimm = 1'b0;
        case (op_code)
            6'b000000: begin
                case (func)
                    6'b100000: dec_alu = 3'b100;
                    6'b100010: dec_alu = 3'b101;
                    6'b100100: dec_alu = 3'b000;
                    6'b100101: dec_alu = 3'b001;
                    6'b100110: dec_alu = 3'b010;
                    6'b100111: dec_alu = 3'b011;
                    6'b101011: dec_alu = 3'b110;
                    6'b000100: dec_alu = 3'b111;
                    default:   dec_ok  = 1'b0;
                endcase
            end
            6'b000010: is_j = 1'b1;
            6'b000100: begin
                is_beq  = 1'b1;
                dec_alu = 3'b101;
            end
            6'b100011, 6'b101011: begin
                is_lw     = (op_code == 6'b100011);
                is_sw     = (op_code == 6'b101011);
                dec_alu   = 3'b100;
                dec_imm   = 1'b1;
                dec_rtimm = 1'b1;
            end
            6'b001000: begin
                dec_alu = 3'b100; dec_imm = 1'b1; dec_rdrt = 1'b1; dec_rtimm = 1'b1;
            end
            6'b001100: begin
                dec_alu = 3'b000; dec_rdrt = 1'b1; dec_rtimm = 1'b1;
            end
            6'b001110: begin
                dec_alu = 3'b010; dec_rdrt = 1'b1; dec_rtimm = 1'b1;
            end
            6'b001011: begin
                dec_alu = 3'b110; dec_rdrt = 1'b1; dec_rtimm = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        PC_Write   = 1'b0;
        PC_s       = 2'b00;
        IR_Write   = 1'b0;
        Write_Reg  = 1'b0;
        Mem_Write  = 1'b0;
        ALU_OP     = 3'b000;
        rd_rt_s    = 1'b0;
        imm_s      = 1'b0;
        rt_imm_s   = 1'b0;
        alu_mem_s  = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_IF: begin
                if (step_ok) begin
                    IR_Write = 1'b1;
                    PC_Write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                if (is_j) begin
                    PC_Write   = 1'b1;
                    PC_s       = 2'b10;
                    instr_done = 1'b1;
                    state_d    = S_IF;
                end else if (!dec_ok) begin
                    illegal_d  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                ALU_OP   = dec_alu;
                rd_rt_s  = dec_rdrt;
                imm_s    = dec_imm;
                rt_imm_s = dec_rtimm;
                if (is_beq) begin
                    PC_Write   = ZF;
                    PC_s       = 2'b01;
                    instr_done = 1'b1;
                    state_d    = S_IF;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                ALU_OP   = dec_alu;
                rd_rt_s  = dec_rdrt;
                imm_s    = dec_imm;
                rt_imm_s = dec_rtimm;
                if (is_sw) begin
                    Mem_Write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_IF;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                ALU_OP     = dec_alu;
                rd_rt_s    = dec_rdrt | is_lw;
                imm_s      = dec_imm;
                rt_imm_s   = dec_rtimm;
                alu_mem_s  = is_lw;
                Write_Reg  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            default: state_d = S_IF;
        endcase
        // Reset masks every enable and select so nothing commits at a reset edge.
        if (!rst_n) begin
            PC_Write   = 1'b0;
            PC_s       = 2'b00;
            IR_Write   = 1'b0;
            Write_Reg  = 1'b0;
            Mem_Write  = 1'b0;
            ALU_OP     = 3'b000;
            rd_rt_s    = 1'b0;
            imm_s      = 1'b0;
            rt_imm_s   = 1'b0;
            alu_mem_s  = 1'b0;
            instr_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign state   = rst_n ? state_q : S_IF;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - scoreboard bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op_code = 6'd0;
    logic [5:0] func = 6'd0;
    logic       ZF = 1'b0;
`ifdef MCC_STEP_EN
    logic       step = 1'b1;
`endif
    logic       PC_Write, IR_Write, Write_Reg, Mem_Write;
    logic [1:0] PC_s;
    logic [2:0] ALU_OP, state;
    logic       rd_rt_s, imm_s, rt_imm_s, alu_mem_s, instr_done, illegal;

    multi_cycle_ctrl dut (
        .clk(clk), .rst_n(rst_n),
`ifdef MCC_STEP_EN
        .step(step),
`endif
        .op_code(op_code), .func(func), .ZF(ZF),
        .PC_Write(PC_Write), .PC_s(PC_s), .IR_Write(IR_Write),
        .Write_Reg(Write_Reg), .Mem_Write(Mem_Write), .ALU_OP(ALU_OP),
        .rd_rt_s(rd_rt_s), .imm_s(imm_s), .rt_imm_s(rt_imm_s),
        .alu_mem_s(alu_mem_s), .state(state), .instr_done(instr_done),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [17:0] exp_q[$];
    logic        m_ill = 1'b0;
    logic        pulse_mode = 1'b0;
    wire  [17:0] obs = {state, PC_Write, PC_s, IR_Write, Write_Reg, Mem_Write, ALU_OP,
                        rd_rt_s, imm_s, rt_imm_s, alu_mem_s, instr_done, illegal};

    function automatic logic [17:0] mk(input logic [2:0] st, input logic pcw,
                                       input logic [1:0] pcs, input logic irw,
                                       input logic wr, input logic mw,
                                       input logic [2:0] alu, input logic rdrt,
                                       input logic imm, input logic rtimm,
                                       input logic alumem, input logic done);
        return {st, pcw, pcs, irw, wr, mw, alu, rdrt, imm, rtimm, alumem, done, m_ill};
    endfunction

    task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic do_cycle(input string tag);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            check_eq(tag, obs, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_zero();
        exp_q.push_back(mk(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic zf);
        logic [2:0] alu;
        logic       ok, rdrt, imm, rtimm;
        int         n;
        op_code = op; func = fn; ZF = zf;
        ok = 1'b1; alu = 3'd0; rdrt = 1'b0; imm = 1'b0; rtimm = 1'b0;
        exp_q.push_back(mk(3'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        case (op)
            6'b000010:
                exp_q.push_back(mk(3'd1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            6'b000100: begin
                exp_q.push_back(mk(3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(mk(3'd2, zf, 2'b01, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            end
            6'b100011, 6'b101011: begin
                exp_q.push_back(mk(3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(mk(3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
                if (op == 6'b100011) begin
                    exp_q.push_back(mk(3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
                    exp_q.push_back(mk(3'd4, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
                end else begin
                    exp_q.push_back(mk(3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
                end
            end
            default: begin
                if (op == 6'b000000) begin
                    case (fn)
                        6'b100000: alu = 3'b100;
                        6'b100010: alu = 3'b101;
                        6'b100100: alu = 3'b000;
                        6'b100101: alu = 3'b001;
                        6'b100110: alu = 3'b010;
                        6'b100111: alu = 3'b011;
                        6'b101011: alu = 3'b110;
                        6'b000100: alu = 3'b111;
                        default:   ok = 1'b0;
                    endcase
                end else begin
                    rdrt = 1'b1; rtimm = 1'b1;
                    case (op)
                        6'b001000: begin alu = 3'b100; imm = 1'b1; end
                        6'b001100: alu = 3'b000;
                        6'b001110: alu = 3'b010;
                        6'b001011: alu = 3'b110;
                        default:   ok = 1'b0;
                    endcase
                end
                if (ok) begin
                    exp_q.push_back(mk(3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                    exp_q.push_back(mk(3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, alu, rdrt, imm, rtimm, 1'b0, 1'b0));
                    exp_q.push_back(mk(3'd4, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, alu, rdrt, imm, rtimm, 1'b0, 1'b1));
                end else begin
                    exp_q.push_back(mk(3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
                    m_ill = 1'b1;
                end
            end
        endcase
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            do_cycle($sformatf("%s c%0d", nm, i));
`ifdef MCC_STEP_EN
            if (pulse_mode && i == 0) step = 1'b0;
`endif
        end
    endtask

    initial begin
        repeat (3) begin
            push_zero();
            do_cycle("reset");
        end
        rst_n = 1'b1;
        run("add", 6'b000000, 6'b100000, 1'b0);
        run("lw", 6'b100011, 6'b000000, 1'b0);
        run("sw", 6'b101011, 6'b000000, 1'b1);
        run("beq_t", 6'b000100, 6'b000000, 1'b1);
        run("beq_nt", 6'b000100, 6'b000000, 1'b0);
        run("j", 6'b000010, 6'b000000, 1'b1);
        run("sub", 6'b000000, 6'b100010, 1'b0);
        run("and", 6'b000000, 6'b100100, 1'b0);
        run("or", 6'b000000, 6'b100101, 1'b0);
        run("xor", 6'b000000, 6'b100110, 1'b0);
        run("nor", 6'b000000, 6'b100111, 1'b0);
        run("sltu", 6'b000000, 6'b101011, 1'b0);
        run("sll", 6'b000000, 6'b000100, 1'b1);
        run("addi", 6'b001000, 6'b000000, 1'b0);
        run("andi", 6'b001100, 6'b000000, 1'b0);
        run("xori", 6'b001110, 6'b000000, 1'b0);
        run("sltiu", 6'b001011, 6'b000000, 1'b0);
        run("ill_op", 6'b111111, 6'b000000, 1'b0);
        run("add_sticky", 6'b000000, 6'b100000, 1'b0);
        run("ill_fn", 6'b000000, 6'b111111, 1'b0);

        // Reset arriving in EX of an add must commit nothing.
        op_code = 6'b000000; func = 6'b100000;
        exp_q.push_back(mk(3'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        do_cycle("mid c0");
        do_cycle("mid c1");
        rst_n = 1'b0;
        push_zero();
        do_cycle("mid rst0");
        m_ill = 1'b0;
        push_zero();
        do_cycle("mid rst1");
        rst_n = 1'b1;
        run("add_post", 6'b000000, 6'b100000, 1'b0);

`ifdef MCC_STEP_EN
        step = 1'b0;
        op_code = 6'b001000; func = 6'b000000;
        repeat (5) begin
            push_zero();
            do_cycle("step hold");
        end
        pulse_mode = 1'b1;
        step = 1'b1;
        run("step_addi", 6'b001000, 6'b000000, 1'b0);
        repeat (2) begin
            push_zero();
            do_cycle("step park");
        end
        pulse_mode = 1'b0;
        step = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle control FSM for the RICPU datapath: ALU, register file, data RAM and instruction fetch. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives every write enable, mux select and ALU_OP of the datapath from the IR-held op_code/func. It replaces the single-cycle combinational decoder, so PC, IR, register file and RAM all run on one clock edge with explicit enables.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- op_code  in  6  Inst_code[31:26] from IR
- func  in  6  Inst_code[5:0] from IR
- ZF  in  1  ALU zero flag, combinational, same cycle
- PC_Write  out  1  load PC this edge
- PC_s  out  2  PC source: 00 PC+4, 01 branch target (PC+4+sext(imm)<<2), 10 jump target
- IR_Write  out  1  load IR from IROM this edge
- Write_Reg  out  1  register-file write enable
- Mem_Write  out  1  data RAM write enable
- ALU_OP  out  3  ALU operation code: 000 and … 111 sll
- rd_rt_s  out  1  1: write address rt, 0: rd
- imm_s  out  1  1: sign-extend imm, 0: zero-extend
- rt_imm_s  out  1  1: ALU B is imm, 0: rt data
- alu_mem_s  out  1  1: write-back data from RAM, 0: from ALU_F
- state  out  3  current FSM state, for debug
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  sticky: an unsupported opcode or func was decoded

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4. Codes 5–7 are unreachable and return to IF.
- IF: IR_Write=1, PC_Write=1, PC_s=00. Next state is ID.
- ID: decode.
  - j (000010): PC_Write=1, PC_s=10, instr_done=1. Next state is IF.
  - Unsupported op or R-type func: illegal is set, instr_done=1, no writes. Next state is IF.
  - All other supported instructions go to EX.
- EX: ALU_OP and selects are driven per instruction.
  - beq (000100): ALU_OP=101, PC_Write=ZF, PC_s=01, instr_done=1. Next state is IF.
  - lw (100011) and sw (101011): ALU_OP=100, imm_s=1, rt_imm_s=1. Next state is MEM.
  - All other instructions go to WB.
- MEM: ALU_OP and selects are held from EX.
  - sw: Mem_Write=1, instr_done=1. Next state is IF.
  - lw: next state is WB.
- WB: Write_Reg=1, instr_done=1, selects held. Next state is IF.
  - lw: alu_mem_s=1, rd_rt_s=1.
- R-type (op 000000), rd_rt_s=0, rt_imm_s=0:
  - func 100000 → ALU_OP=100
  - func 100010 → ALU_OP=101
  - func 100100 → ALU_OP=000
  - func 100101 → ALU_OP=001
  - func 100110 → ALU_OP=010
  - func 100111 → ALU_OP=011
  - func 101011 → ALU_OP=110
  - func 000100 → ALU_OP=111
- I-type, rd_rt_s=1, rt_imm_s=1:
  - addi 001000 → ALU_OP=100, imm_s=1
  - andi 001100 → ALU_OP=000, imm_s=0
  - xori 001110 → ALU_OP=010, imm_s=0
  - sltiu 001011 → ALU_OP=110, imm_s=0
- Every output not listed for a state is 0.
- Outputs are Moore-style: decoded from state and the IR fields. beq PC_Write is the only output that depends on ZF.
- illegal clears only on reset.

## Timing
- State register updates on the rising edge of clk.
- Reset: when rst_n=0 at an edge, state becomes IF and illegal becomes 0.
- While rst_n=0, all enables are forced to 0 combinationally: PC_Write, IR_Write, Write_Reg, Mem_Write and instr_done.
- While rst_n=0, ALU_OP and all selects are 000/0, and state reads 0.
- Reset mid-instruction: no write of any kind is committed at that edge. The first IF after release fetches the PC value the datapath holds.
- Cycles per instruction:
  - j: 2
  - illegal: 2
  - beq: 3
  - sw: 4
  - R-type and I-type ALU: 4
  - lw: 5
- IR is stable from the ID cycle to the end of the instruction, because IR_Write is asserted only in IF.
- Register-file write happens at the WB edge. An immediately following instruction reads the new value in its ID/EX cycles.
- Register address 0 writes are discarded by the register file, not by this block.

## Configuration
- MCC_STEP_EN defined:
  - Adds input port step (1 bit).
  - In IF, the FSM holds with PC_Write=0 and IR_Write=0 while step=0.
  - When step=1, it performs the normal IF actions and advances.
  - step is sampled only in IF. One pulse executes exactly one instruction.
- MCC_STEP_EN undefined:
  - No step port. IF always advances after one cycle.

## Test plan
- Reset: rst_n=0 for 3 cycles with op_code=000000 → state=0, every enable 0, illegal=0. First cycle after release has IR_Write=1 and PC_Write=1.
- add (op 000000, func 100000) → state sequence 0,1,2,4,0.
  - Write_Reg=1 only in state 4, with ALU_OP=100 and rd_rt_s=0.
  - instr_done pulses once.
- lw (op 100011) → state sequence 0,1,2,3,4,0.
  - In WB: alu_mem_s=1, rd_rt_s=1, ALU_OP=100, imm_s=1.
  - Mem_Write=0 throughout.
- sw (op 101011) → state sequence 0,1,2,3,0.
  - Mem_Write=1 only in state 3.
  - Write_Reg is never 1.
- beq (op 000100):
  - With ZF=1 in EX: PC_Write=1, PC_s=01.
  - With ZF=0 in EX: PC_Write=0.
  - Both cases take 3 cycles.
- Illegal op 111111 → illegal=1 from the cycle after ID, no write enables asserted, back in IF after 2 cycles. illegal is still 1 after a following valid add.
- With MCC_STEP_EN and step=0 held for 5 cycles → state stays 0 with no enables. A single step=1 pulse runs one addi in 4 cycles and then holds in IF.
